// File: rtl/data_bus_if.sv
// data_bus_if: data-side bus bridge running one classic Wishbone cycle per memory-stage request.
module data_bus_if (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_FOR_STALL} state_t;
  state_t state, state_n;
  logic [31:0] rd_buf;
  logic issue, done;
  assign issue = state == IDLE && cpu_ce_i && !flush_i;
  assign done  = state == BUSY && wb_ack_i && !flush_i;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state == IDLE ? (issue ? BUSY : IDLE)
            : state == BUSY ? (flush_i ? IDLE : wb_ack_i ? (|stall_i ? WAIT_FOR_STALL : IDLE) : BUSY)
            : (flush_i || ~|stall_i) ? IDLE : WAIT_FOR_STALL;
  end
  always_comb begin
    stallreq_o = state == IDLE ? issue : state == BUSY ? !(flush_i || wb_ack_i) : 1'b0;
    cpu_data_o = (done && !wb_we_o) ? wb_data_i : state == WAIT_FOR_STALL ? rd_buf : 32'h0;
  end
  // a flush in BUSY abandons the cycle; a late ack then finds IDLE and is ignored
  always_ff @(posedge clk) begin
    if (rst || (state == BUSY && (flush_i || wb_ack_i))) begin
      wb_addr_o <= '0;
      wb_data_o <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else if (issue) begin
      wb_addr_o <= cpu_addr_i;
      wb_data_o <= cpu_data_i;
      wb_we_o   <= cpu_we_i;
      wb_sel_o  <= cpu_sel_i;
      wb_stb_o  <= 1'b1;
      wb_cyc_o  <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) rd_buf <= '0;
    else if (done && !wb_we_o) rd_buf <= wb_data_i;
endmodule
